// File: rtl/mic1_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mic1_run_ctrl
//  Purpose  : Run/step/stop controller for the MIC-1 SoC. Debounces three
//             pre-synchronised buttons, then lets the core run freely, run a
//             burst of N clocks per step press, or halt on a PC breakpoint.
//             Also drives the status LEDs and a saturating count of run clocks.
//  Config   : BREAKPOINT_EN - when defined, the PC breakpoint compare is built
//             and the BREAK state is reachable. When undefined, the compare is
//             removed, bp_hit is tied low and state never reads 3.
//  Ports    : clk        system clock
//             resetn     asynchronous active-low reset
//             btn_run    start button (synchronised, active-high)
//             btn_step   step button  (synchronised, active-high)
//             btn_stop   stop button  (synchronised, active-high)
//             step_n     clocks per step burst (0 behaves as 1)
//             pc         current MIC-1 program counter
//             bp_en      breakpoint enable
//             bp_addr    breakpoint PC value
//             mic1_run   clock enable to mic1_soc
//             led_run    copy of mic1_run
//             led_idle   inverse of mic1_run
//             bp_hit     sticky breakpoint flag
//             state      0 IDLE, 1 RUN, 2 STEP, 3 BREAK
//             run_cycles clocks spent with mic1_run=1 (saturating)
//  Revision : 1.0  initial release
// ============================================================================
module mic1_run_ctrl #(
  parameter int DEB_COUNT = 511,
  parameter int STEP_W    = 8,
  parameter int CNT_W     = 32,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              btn_run,
  input  logic              btn_step,
  input  logic              btn_stop,
  input  logic [STEP_W-1:0] step_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              mic1_run,
  output logic              led_run,
  output logic              led_idle,
  output logic              bp_hit,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  run_cycles
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STEP  = 2'd2;
  localparam logic [1:0] ST_BREAK = 2'd3;

  localparam int              DEB_W    = (DEB_COUNT > 0) ? $clog2(DEB_COUNT + 1) : 1;
  localparam logic [DEB_W-1:0] DEB_LOAD = DEB_W'(DEB_COUNT);

  // --------------------------------------------------------------------------
  // Debounce: bit 0 run, bit 1 step, bit 2 stop.
  // The counter is reloaded whenever raw agrees with the debounced level, so
  // the level only flips after raw has disagreed on DEB_COUNT+1 consecutive
  // clocks (DEB_COUNT decrements, then the update on the clock it reads 0).
  // --------------------------------------------------------------------------
  logic [2:0] raw;
  logic [2:0] deb;

  assign raw = {btn_stop, btn_step, btn_run};

  for (genvar i = 0; i < 3; i++) begin : g_deb
    logic [DEB_W-1:0] cnt;
    logic             level;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        cnt   <= DEB_LOAD;
        level <= 1'b0;
      end else if (raw[i] == level) begin
        cnt   <= DEB_LOAD;
      end else if (cnt == '0) begin
        level <= raw[i];
        cnt   <= DEB_LOAD;
      end else begin
        cnt   <= cnt - DEB_W'(1);
      end
    end

    assign deb[i] = level;
  end

  // --------------------------------------------------------------------------
  // Edge detection on the debounced run/step levels; stop is level-sensitive.
  // --------------------------------------------------------------------------
  logic run_prev;
  logic step_prev;
  logic run_e;
  logic step_e;
  logic stop_lvl;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_prev  <= 1'b0;
      step_prev <= 1'b0;
    end else begin
      run_prev  <= deb[0];
      step_prev <= deb[1];
    end
  end

  assign run_e    = deb[0] & ~run_prev;
  assign step_e   = deb[1] & ~step_prev;
  assign stop_lvl = deb[2];

  assign mic1_run = (state == ST_RUN) || (state == ST_STEP);
  assign led_run  = mic1_run;
  assign led_idle = ~mic1_run;

  // --------------------------------------------------------------------------
  // Breakpoint compare
  // --------------------------------------------------------------------------
  logic bp_match;
  logic [1:0]        state_nxt;
  logic [STEP_W-1:0] step_cnt;
  logic [STEP_W-1:0] step_cnt_nxt;

`ifdef BREAKPOINT_EN
  // bp_skip masks the compare during the first clock after leaving BREAK, so
  // resuming from the breakpoint address does not immediately halt again.
  logic bp_skip;
  logic bp_hit_r;

  assign bp_match = bp_en && (pc == bp_addr) && mic1_run && !bp_skip;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bp_skip  <= 1'b0;
      bp_hit_r <= 1'b0;
    end else begin
      bp_skip <= (state == ST_BREAK) &&
                 ((state_nxt == ST_RUN) || (state_nxt == ST_STEP));
      if ((state != ST_BREAK) && (state_nxt == ST_BREAK)) begin
        bp_hit_r <= 1'b1;
      end else if ((state == ST_BREAK) &&
                   ((state_nxt == ST_RUN) || (state_nxt == ST_STEP))) begin
        bp_hit_r <= 1'b0;
      end
    end
  end

  assign bp_hit = bp_hit_r;
`else
  logic unused_bp;

  assign unused_bp = ^{bp_en, bp_addr, pc};
  assign bp_match  = 1'b0;
  assign bp_hit    = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Control FSM. Priority: stop > breakpoint > run edge > step edge.
  // The burst counter is loaded with max(step_n,1)-1 on STEP entry and the
  // burst ends on the clock it reads 0, giving max(step_n,1) run clocks.
  // --------------------------------------------------------------------------
  logic [STEP_W-1:0] step_load;

  assign step_load = (step_n == '0) ? '0 : (step_n - STEP_W'(1));

  always_comb begin
    state_nxt    = state;
    step_cnt_nxt = step_cnt;
    case (state)
      ST_IDLE: begin
        if (stop_lvl) begin
          state_nxt = ST_IDLE;
        end else if (run_e) begin
          state_nxt = ST_RUN;
        end else if (step_e) begin
          state_nxt    = ST_STEP;
          step_cnt_nxt = step_load;
        end
      end
      ST_RUN: begin
        if (stop_lvl) begin
          state_nxt = ST_IDLE;
        end else if (bp_match) begin
          state_nxt = ST_BREAK;
        end
      end
      ST_STEP: begin
        if (stop_lvl) begin
          state_nxt = ST_IDLE;
        end else if (bp_match) begin
          state_nxt = ST_BREAK;
        end else if (step_cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          step_cnt_nxt = step_cnt - STEP_W'(1);
        end
      end
      ST_BREAK: begin
        if (stop_lvl) begin
          state_nxt = ST_IDLE;
        end else if (run_e) begin
          state_nxt = ST_RUN;
        end else if (step_e) begin
          state_nxt    = ST_STEP;
          step_cnt_nxt = step_load;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      step_cnt <= '0;
    end else begin
      state    <= state_nxt;
      step_cnt <= step_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Saturating run-clock counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_cycles <= '0;
    end else if (mic1_run && (run_cycles != '1)) begin
      run_cycles <= run_cycles + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mic1_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mic1_run_ctrl
//  Purpose  : Self-checking bench for mic1_run_ctrl (DEB_COUNT=3, STEP_W=8,
//             CNT_W=16). A second instance with CNT_W=2 shares all inputs and
//             exercises counter saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mic1_run_ctrl;

`ifdef BREAKPOINT_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        btn_run = 1'b0;
  logic        btn_step = 1'b0;
  logic        btn_stop = 1'b0;
  logic [7:0]  step_n = 8'd0;
  logic [15:0] pc = 16'd0;
  logic        bp_en = 1'b0;
  logic [15:0] bp_addr = 16'h0040;

  logic        mic1_run, led_run, led_idle, bp_hit;
  logic [1:0]  state;
  logic [15:0] run_cycles;

  logic        s_mic1_run, s_led_run, s_led_idle, s_bp_hit;
  logic [1:0]  s_state;
  logic [1:0]  s_run_cycles;

  always #5 clk = ~clk;

  mic1_run_ctrl #(.DEB_COUNT(3), .STEP_W(8), .CNT_W(16), .ADDR_W(16)) dut (
    .clk(clk), .resetn(resetn), .btn_run(btn_run), .btn_step(btn_step),
    .btn_stop(btn_stop), .step_n(step_n), .pc(pc), .bp_en(bp_en),
    .bp_addr(bp_addr), .mic1_run(mic1_run), .led_run(led_run),
    .led_idle(led_idle), .bp_hit(bp_hit), .state(state),
    .run_cycles(run_cycles)
  );

  mic1_run_ctrl #(.DEB_COUNT(3), .STEP_W(8), .CNT_W(2), .ADDR_W(16)) dut_sat (
    .clk(clk), .resetn(resetn), .btn_run(btn_run), .btn_step(btn_step),
    .btn_stop(btn_stop), .step_n(step_n), .pc(pc), .bp_en(bp_en),
    .bp_addr(bp_addr), .mic1_run(s_mic1_run), .led_run(s_led_run),
    .led_idle(s_led_idle), .bp_hit(s_bp_hit), .state(s_state),
    .run_cycles(s_run_cycles)
  );

  typedef struct {
    logic       run;
    logic       step;
    logic       stop;
    logic [7:0] sn;
    int         ticks;
    logic [1:0] st;
    logic       mrun;
    int         cyc;
    int         high;
  } vec_t;

  vec_t vecs[17];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          run  step stop sn     ticks st    mrun cyc high
    vecs[0]  = '{1'b0,1'b0,1'b0,8'd0,  2,  2'd0,1'b0, 0, 0}; // idle after reset
    vecs[1]  = '{1'b1,1'b0,1'b0,8'd0,  3,  2'd0,1'b0, 0, 0}; // 3-clock glitch
    vecs[2]  = '{1'b0,1'b0,1'b0,8'd0,  6,  2'd0,1'b0, 0, 0};
    vecs[3]  = '{1'b0,1'b1,1'b0,8'd5, 12,  2'd0,1'b0, 5, 5}; // burst of 5
    vecs[4]  = '{1'b0,1'b0,1'b0,8'd5,  6,  2'd0,1'b0, 5, 0};
    vecs[5]  = '{1'b0,1'b1,1'b0,8'd0,  8,  2'd0,1'b0, 6, 1}; // step_n=0 -> 1
    vecs[6]  = '{1'b0,1'b0,1'b0,8'd0,  6,  2'd0,1'b0, 6, 0};
    vecs[7]  = '{1'b0,1'b1,1'b0,8'd200,10, 2'd2,1'b1,11, 6}; // long burst
    vecs[8]  = '{1'b0,1'b1,1'b1,8'd200, 5, 2'd0,1'b0,16, 4}; // stop abort
    vecs[9]  = '{1'b0,1'b0,1'b0,8'd200, 6, 2'd0,1'b0,16, 0};
    vecs[10] = '{1'b1,1'b0,1'b1,8'd0,  8,  2'd0,1'b0,16, 0}; // run+stop together
    vecs[11] = '{1'b1,1'b0,1'b0,8'd0,  6,  2'd0,1'b0,16, 0}; // no stale run edge
    vecs[12] = '{1'b0,1'b0,1'b0,8'd0,  6,  2'd0,1'b0,16, 0};
    vecs[13] = '{1'b1,1'b0,1'b0,8'd0,  7,  2'd1,1'b1,18, 3}; // free run
    vecs[14] = '{1'b0,1'b1,1'b0,8'd3,  6,  2'd1,1'b1,24, 6}; // step ignored in RUN
    vecs[15] = '{1'b0,1'b0,1'b1,8'd3,  5,  2'd0,1'b0,29, 4}; // stop from RUN
    vecs[16] = '{1'b0,1'b0,1'b0,8'd3,  6,  2'd0,1'b0,29, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", int'(state), 0);
    check("reset_mic1_run", int'(mic1_run), 0);
    check("reset_led_idle", int'(led_idle), 1);
    check("reset_run_cycles", int'(run_cycles), 0);
    check("reset_bp_hit", int'(bp_hit), 0);
    resetn = 1'b1;

    // Table-driven sequence
    for (int v = 0; v < 17; v++) begin
      int high;
      int sat_exp;
      btn_run  = vecs[v].run;
      btn_step = vecs[v].step;
      btn_stop = vecs[v].stop;
      step_n   = vecs[v].sn;
      high = 0;
      for (int t = 0; t < vecs[v].ticks; t++) begin
        tick();
        if (mic1_run) high++;
      end
      sat_exp = (vecs[v].cyc > 3) ? 3 : vecs[v].cyc;
      check($sformatf("v%0d_state", v), int'(state), int'(vecs[v].st));
      check($sformatf("v%0d_mic1_run", v), int'(mic1_run), int'(vecs[v].mrun));
      check($sformatf("v%0d_led_run", v), int'(led_run), int'(vecs[v].mrun));
      check($sformatf("v%0d_led_idle", v), int'(led_idle), int'(!vecs[v].mrun));
      check($sformatf("v%0d_run_cycles", v), int'(run_cycles), vecs[v].cyc);
      check($sformatf("v%0d_run_clocks", v), high, vecs[v].high);
      check($sformatf("v%0d_sat_cycles", v), int'(s_run_cycles), sat_exp);
      check($sformatf("v%0d_bp_hit", v), int'(bp_hit), 0);
    end

    // Asynchronous reset in the middle of RUN, checked before any clock edge
    btn_run = 1'b1;
    repeat (7) tick();
    check("pre_reset_state", int'(state), 1);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_mic1_run", int'(mic1_run), 0);
    check("async_rst_led_idle", int'(led_idle), 1);
    check("async_rst_run_cycles", int'(run_cycles), 0);
    check("async_rst_state", int'(state), 0);
    btn_run = 1'b0;
    #3;
    resetn = 1'b1;
    repeat (6) tick();
    check("post_reset_idle", int'(state), 0);

    // Breakpoint: halt one clock after the match, then resume without re-trigger
    bp_en   = 1'b1;
    bp_addr = 16'h0040;
    pc      = 16'h003E;
    btn_run = 1'b1;
    repeat (5) tick();
    check("bp_run_entered", int'(state), 1);
    pc = 16'h0040;
    tick();
    check("bp_state", int'(state), BP ? 3 : 1);
    check("bp_mic1_run", int'(mic1_run), BP ? 0 : 1);
    check("bp_hit_set", int'(bp_hit), BP ? 1 : 0);
    btn_run = 1'b0;
    repeat (6) tick();
    check("bp_held_state", int'(state), BP ? 3 : 1);
    check("bp_hit_held", int'(bp_hit), BP ? 1 : 0);
    btn_run = 1'b1;
    repeat (5) tick();
    check("bp_resume_state", int'(state), 1);
    check("bp_resume_hit", int'(bp_hit), 0);
    tick();
    check("bp_no_retrigger", int'(state), 1);
    pc = 16'h0041;
    tick();
    check("bp_moved_on", int'(state), 1);
    check("bp_moved_mic1_run", int'(mic1_run), 1);

    btn_run  = 1'b0;
    btn_stop = 1'b1;
    repeat (6) tick();
    check("final_stop_state", int'(state), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
